// File: rtl/sap_sequencer.sv
// SAP CPU timing core: clock-enable divider, microcode step counter, halt/debug-step FSM, retire count.
// Optional interrupt injection at instruction boundaries when SAP_SEQ_IRQ_EN is defined.
module sap_sequencer #(
  parameter int CLK_DIV           = 4,
  parameter int INSTRUCTION_STEPS = 32,
  parameter int RETIRE_WIDTH      = 32,
  localparam int STEP_WIDTH       = $clog2(INSTRUCTION_STEPS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_halt,
  input  logic                    i_adv,
  input  logic                    i_run_mode,
  input  logic                    i_step_req,
  input  logic                    i_irq,
  input  logic                    i_ei,
  input  logic                    i_di,
  output logic                    o_clk_en,
  output logic [STEP_WIDTH-1:0]   o_step,
  output logic                    o_halted,
  output logic                    o_paused,
  output logic                    o_irq_take,
  output logic [RETIRE_WIDTH-1:0] o_retired,
  output logic                    o_overrun
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]      DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [STEP_WIDTH-1:0] STEP_LAST = STEP_WIDTH'(INSTRUCTION_STEPS - 1);

  typedef enum logic [1:0] {ST_RUN, ST_PAUSED, ST_HALTED} state_e;

  state_e                  state_q, state_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic                    clk_en_q, clk_en_d;
  logic [STEP_WIDTH-1:0]   step_q, step_d;
  logic                    halted_q, halted_d;
  logic                    paused_q, paused_d;
  logic [RETIRE_WIDTH-1:0] retired_q, retired_d;
  logic                    overrun_q, overrun_d;
  logic                    boundary;

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    step_d    = step_q;
    retired_d = retired_q;
    overrun_d = overrun_q;
    boundary  = 1'b0;
    case (state_q)
      ST_RUN: begin
        div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        if (clk_en_q) begin
          if (i_halt) begin
            state_d = ST_HALTED;
          end else begin
            if (i_adv) begin
              boundary = 1'b1;
            end else if (step_q == STEP_LAST) begin
              boundary  = 1'b1;
              overrun_d = 1'b1;
            end else begin
              step_d = step_q + 1'b1;
            end
            if (boundary) begin
              step_d    = '0;
              retired_d = retired_q + 1'b1;
              if (i_run_mode) state_d = ST_PAUSED;
            end
          end
        end
      end
      ST_PAUSED: begin
        div_d = '0;
        if (i_step_req || !i_run_mode) state_d = ST_RUN;
      end
      default: ;
    endcase
    // The enable is suppressed in the very clk that leaves RUN so CLK_DIV=1 stops immediately.
    clk_en_d = (state_q == ST_RUN) && (state_d == ST_RUN) && (div_q == DIV_LAST);
    halted_d = (state_d == ST_HALTED);
    paused_d = (state_d == ST_PAUSED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUN;
      div_q     <= '0;
      clk_en_q  <= 1'b0;
      step_q    <= '0;
      halted_q  <= 1'b0;
      paused_q  <= 1'b0;
      retired_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      clk_en_q  <= clk_en_d;
      step_q    <= step_d;
      halted_q  <= halted_d;
      paused_q  <= paused_d;
      retired_q <= retired_d;
      overrun_q <= overrun_d;
    end
  end

`ifdef SAP_SEQ_IRQ_EN
  logic ie_q, ie_d;
  logic irq_pend_q, irq_pend_d;
  logic irq_take_q, irq_take_d;

  always_comb begin
    ie_d       = ie_q;
    irq_pend_d = irq_pend_q;
    irq_take_d = irq_take_q;
    if (state_q == ST_RUN && clk_en_q) begin
      irq_take_d = 1'b0;
      if (i_di)      ie_d = 1'b0;
      else if (i_ei) ie_d = 1'b1;
      if (boundary && ie_q && i_irq) begin
        ie_d = 1'b0;
        // A paused boundary defers the take until the debugger releases the next instruction.
        if (state_d == ST_PAUSED) irq_pend_d = 1'b1;
        else                      irq_take_d = 1'b1;
      end
    end else if (state_q == ST_PAUSED && state_d == ST_RUN && irq_pend_q) begin
      irq_pend_d = 1'b0;
      irq_take_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ie_q       <= 1'b0;
      irq_pend_q <= 1'b0;
      irq_take_q <= 1'b0;
    end else begin
      ie_q       <= ie_d;
      irq_pend_q <= irq_pend_d;
      irq_take_q <= irq_take_d;
    end
  end

  assign o_irq_take = irq_take_q;
`else
  logic unused_irq;
  assign unused_irq = ^{i_irq, i_ei, i_di};
  assign o_irq_take = 1'b0;
`endif

  assign o_clk_en  = clk_en_q;
  assign o_step    = step_q;
  assign o_halted  = halted_q;
  assign o_paused  = paused_q;
  assign o_retired = retired_q;
  assign o_overrun = overrun_q;

endmodule
